alu_req_arbiter: RTL and testbench



---
 rtl/alu_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one pipelined ALU/NPU core between two valid/ready
// requesters, tags each issued op with its owner and steers the returned
// status word into that owner's response FIFO.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 first);
// the default build uses round-robin arbitration.
module alu_req_arbiter #(
  parameter int ALU_LAT = 2,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [12:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [12:0] req1_data,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [7:0]  rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [7:0]  rsp1_data,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_mode,
  input  logic [7:0]  alu_status,
  output logic        busy
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [1:0]       req_valid;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [1:0]       rsp_ready;
  logic [1:0]       rsp_valid;
  logic [1:0]       cnt_nz;
  logic [12:0]      req_data [2];
  logic [7:0]       rsp_data [2];
  logic [ALU_LAT:0] tag_v;
  logic [ALU_LAT:0] tag_o;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;
  assign rsp_ready   = {rsp1_ready, rsp0_ready};
  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_data   = rsp_data[0];
  assign rsp1_data   = rsp_data[1];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: req0 wins whenever eligible
  always_comb begin
    grant = '0;
    if (elig[0])      grant = 2'b01;
    else if (elig[1]) grant = 2'b10;
  end
`else
  logic last1;

  // Round-robin: on contention the requester not granted last wins
  always_comb begin
    grant = elig;
    if (elig == 2'b11) grant = last1 ? 2'b01 : 2'b10;
  end

  // Remember last winner; reset value makes req0 the first favourite
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last1 <= 1'b1;
    else if (|grant) last1 <= grant[1];
  end
`endif

  // Operand/opcode register to the core, held while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      {alu_mode, alu_op, alu_b, alu_a} <= '0;
    else if (|grant) {alu_mode, alu_op, alu_b, alu_a} <= grant[1] ? req_data[1] : req_data[0];
  end

  // Owner tag pipeline; the last stage marks the cycle the core status is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v <= {tag_v[ALU_LAT-1:0], |grant};
      tag_o <= {tag_o[ALU_LAT-1:0], grant[1]};
    end
  end

  // Busy tracks the registered outstanding counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 1'b0;
    else        busy <= |cnt_nz;
  end

  for (genvar n = 0; n < 2; n++) begin : g_req
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] fcnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [7:0]    mem [MAX_OUT];
    logic          push;
    logic          pop;

    assign push         = tag_v[ALU_LAT] && (tag_o[ALU_LAT] == 1'(n));
    assign pop          = rsp_valid[n] && rsp_ready[n];
    assign elig[n]      = req_valid[n] && (cnt < CW'(MAX_OUT));
    assign cnt_nz[n]    = |cnt_next;
    assign rsp_valid[n] = |fcnt;
    assign rsp_data[n]  = mem[rd_ptr];

    // Outstanding count: in flight plus buffered
    always_comb begin
      cnt_next = cnt;
      case ({grant[n], pop})
        2'b10:   cnt_next = cnt + 1'b1;
        2'b01:   cnt_next = cnt - 1'b1;
        default: cnt_next = cnt;
      endcase
    end

    // Outstanding count register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_next;
    end

    // Response FIFO; credit accounting keeps it from overflowing
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fcnt   <= '0;
        for (int unsigned i = 0; i < MAX_OUT; i++) mem[PW'(i)] <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= alu_status;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   fcnt <= fcnt + 1'b1;
          2'b01:   fcnt <= fcnt - 1'b1;
          default: fcnt <= fcnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a small core model drives alu_status; a
// transaction-level reference (credit counts, arbitration rule, per-owner
// queues of expected status with arrival times) is compared every cycle.
module tb_alu_req_arbiter;
  localparam int ALU_LAT = 2;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [12:0] req0_data = '0, req1_data = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [7:0]  rsp0_data, rsp1_data;
  logic [3:0]  alu_a, alu_b, alu_op;
  logic        alu_mode;
  logic [7:0]  alu_status = '0;
  logic [7:0]  st1 = '0;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  alu_req_arbiter #(.ALU_LAT(ALU_LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mode(alu_mode),
    .alu_status(alu_status), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core behaviour: {Zero,Carry,Sign,Error,Result}
  function automatic logic [7:0] alu_f(input logic [12:0] d);
    logic [3:0] a, b, op, res;
    logic       mode, c, e;
    logic [4:0] s;
    logic [7:0] p;
    a = d[3:0]; b = d[7:4]; op = d[11:8]; mode = d[12];
    c = 1'b0; e = 1'b0; res = '0;
    p = {4'b0, a} * {4'b0, b};
    if (!mode) begin
      case (op)
        4'd0: begin s = {1'b0, a} + {1'b0, b}; res = s[3:0]; c = s[4]; end
        4'd1: begin s = {1'b0, a} - {1'b0, b}; res = s[3:0]; c = s[4]; end
        4'd2: res = a & b;
        4'd3: if (b == 4'd0) e = 1'b1; else res = a / b;
        4'd4: res = a | b;
        4'd5: res = a ^ b;
        default: res = p[3:0];
      endcase
    end else begin
      res = p[5:2] ^ op;
    end
    return {(res == 4'd0), c, res[3], e, res};
  endfunction

  // Core pipeline: status register lags the operand registers by ALU_LAT edges
  always @(posedge clk) begin
    st1        <= alu_f({alu_mode, alu_op, alu_b, alu_a});
    alu_status <= st1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model state
  int         mcnt [2];
  logic       mlast1;
  logic [7:0] mq_st [2][16];
  int         mq_av [2][16];
  int         mq_h [2];
  int         mq_n [2];

  // Monitor/scoreboard, sampled on the falling edge
  always @(negedge clk) begin : mon
    logic [1:0]  v, e, g, rr, ev;
    logic [1:0]  act_rdy, act_v;
    logic [7:0]  act_d [2];
    logic [12:0] dd [2];
    int          idx;
    if (!rst_n) begin
      mcnt = '{0, 0}; mq_h = '{0, 0}; mq_n = '{0, 0}; mlast1 = 1'b1;
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_busy", busy, 0);
    end else begin
      v = {req1_valid, req0_valid};
      rr = {rsp1_ready, rsp0_ready};
      dd[0] = req0_data; dd[1] = req1_data;
      act_rdy = {req1_ready, req0_ready};
      act_v = {rsp1_valid, rsp0_valid};
      act_d[0] = rsp0_data; act_d[1] = rsp1_data;
      for (int n = 0; n < 2; n++) e[n] = v[n] && (mcnt[n] < MAX_OUT);
      g = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (e[0]) g[0] = 1'b1;
      else if (e[1]) g[1] = 1'b1;
`else
      if (e[0] && e[1]) g[mlast1 ? 0 : 1] = 1'b1;
      else if (e[0]) g[0] = 1'b1;
      else if (e[1]) g[1] = 1'b1;
`endif
      chk("req0_ready", act_rdy[0], g[0]);
      chk("req1_ready", act_rdy[1], g[1]);
      for (int n = 0; n < 2; n++) begin
        ev[n] = (mq_n[n] > 0) && (mq_av[n][mq_h[n]] <= cyc);
        chk(n == 0 ? "rsp0_valid" : "rsp1_valid", act_v[n], ev[n]);
        if (ev[n]) chk(n == 0 ? "rsp0_data" : "rsp1_data", act_d[n], mq_st[n][mq_h[n]]);
      end
      chk("busy", busy, (mcnt[0] + mcnt[1]) > 0);
      for (int n = 0; n < 2; n++) begin
        if (ev[n] && rr[n]) begin
          mq_h[n] = (mq_h[n] + 1) % 16;
          mq_n[n]--;
          mcnt[n]--;
        end
        if (g[n]) begin
          idx = (mq_h[n] + mq_n[n]) % 16;
          mq_st[n][idx] = alu_f(dd[n]);
          mq_av[n][idx] = cyc + ALU_LAT + 2;
          mq_n[n]++;
          mcnt[n]++;
          mlast1 = (n == 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    // add 3+4 on req0
    req0_data = 13'h0043; req0_valid = 1'b1; tick(); req0_valid = 1'b0;
    repeat (5) tick();
    // divide by zero on req0
    req0_data = 13'h0309; req0_valid = 1'b1; tick(); req0_valid = 1'b0;
    repeat (5) tick();
    // contention, both responses drained
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (8) begin
      req0_data = 13'($urandom); req1_data = 13'($urandom); tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) tick();
    // req0 response path stalled, credits exhausted, then one pop
    rsp0_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (6) begin
      req0_data = 13'($urandom); req1_data = 13'($urandom); tick();
    end
    rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
    repeat (3) tick();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1;
    repeat (8) tick();
    // reset with ops in flight
    req0_data = 13'($urandom); req1_data = 13'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1; tick(); tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (8) tick();
    // randomized traffic with occasional resets
    repeat (3000) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_data = 13'($urandom); req1_data = 13'($urandom);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end
    // drain
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    chk("final_busy", busy, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
